gemm_ctrl: RTL
==============

# gemm_ctrl

Sequencer for one GEMM tile job around `src_buf`, the MAC core and `dst_buf`.
- Accepts 32 64-bit source beats from the DMA input stream and writes them into `src_buf`.
- Sweeps the `src_buf` read index for the core, and steers core results into `dst_buf`.
- Streams the 16 64-bit result beats back to the DMA output stream.

## Interface
Parameters:
- `NPASS`, default 1: number of full `ia` 0..63 sweeps per job (1..15).

Ports. Clock `clk`; reset `reset` is asynchronous and active-high.
- `clk` in 1: clock.
- `reset` in 1: async active-high reset.
- `start` in 1: job start pulse. Ignored unless `busy`=0.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last output beat handshake.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 64: source stream.
- `src_v` out 1, `src_a` out 5, `src_d` out 64: `src_buf` write port.
- `exec` out 1, `ia` out 6: `src_buf` read and core-issue port.
- `result_v` in 1: core result strobe. `result` goes to `dst_buf` directly, not through this block.
- `outr` out 1, `oa` out 5: `dst_buf` write port.
- `dst_v` out 1, `dst_a` out 4: `dst_buf` read port.
- `dst_d` in 64: `dst_buf` read data.
- `m_valid` out 1, `m_ready` in 1, `m_data` out 64, `m_last` out 1: result stream.
- `err` out 1: sticky protocol error flag (see Configuration).

## Operation
- States: IDLE → LOAD → EXEC → WAIT → DRAIN → IDLE.
- IDLE:
  - all strobes low, `s_ready`=0.
  - `start`=1 → LOAD; clears the beat, index and result counters.
- LOAD:
  - `s_ready`=1.
  - Each `s_valid&s_ready` beat n (0..31) registers `src_v`=1, `src_a`=n, `src_d`=`s_data` for the next cycle.
  - After the 32nd handshake, `s_ready` drops and the state goes to EXEC.
- EXEC:
  - `exec`=1 every cycle; `ia` counts 0..63 and wraps, for `NPASS`×64 cycles, then → WAIT.
  - The final LOAD write (`src_a`=31, bank 1) lands in the first EXEC cycle, while `ia`=0 reads bank 0, so there is no collision.
- Results, accepted in EXEC and WAIT:
  - `outr` = `result_v` & (rcnt<32). This is combinational from `result_v`.
  - `oa` = rcnt; rcnt increments on each `outr`.
  - Excess results, or `result_v` seen in IDLE, LOAD or DRAIN, never assert `outr`.
- WAIT: → DRAIN when rcnt=32. If rcnt already reaches 32 during EXEC, WAIT lasts one cycle.
- DRAIN, for beat k = 0..15:
  - Issue `dst_v`=1 with `dst_a`=k.
  - Hold `dst_a`=k the following cycle and capture `dst_d` into `m_data`.
  - Assert `m_valid`; hold `m_valid` and `m_data` until `m_ready`.
  - `m_last`=1 on k=15.
  - `dst_v` for k+1 is issued in the same cycle as the beat-k handshake.
- After the k=15 handshake: `done`=1 for one cycle, then IDLE. `busy` falls together with `done`.
- `start` while `busy`=1 is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- `reset` mid-job aborts immediately. Stream handshakes in flight are dropped; no buffer writes occur after reset assertion.
- `src_v` lags its `s_valid&s_ready` handshake by exactly 1 cycle.
- EXEC length is exactly `NPASS`×64 cycles. `ia` is registered; `exec` and `ia` change together.
- `outr` and `oa` are valid in the same cycle as `result_v`.
- DRAIN:
  - First `m_valid` is 2 cycles after the first `dst_v`.
  - With `m_ready` held high, one beat every 2 cycles.
  - `m_data`, `m_last` and `m_valid` are stable while `m_valid&~m_ready`.
- Minimum job length, with no stalls and zero core latency: 32 + 1 + 64·`NPASS` + 1 + 33 cycles.

## Configuration
- `GEMM_CTRL_ERR_EN` defined:
  - `err` sets on `result_v` outside EXEC/WAIT, or on `result_v` with rcnt=32.
  - `err` clears only on `reset` or an accepted `start`.
- `GEMM_CTRL_ERR_EN` undefined: `err` is tied 0. Such results are still silently dropped.

## Test plan
- Reset mid-LOAD after 10 beats → all outputs 0 next cycle. A new job loads all 32 beats and `src_a` restarts at 0.
- Full job, `NPASS`=1, core returns results with fixed 3-cycle latency → 32 `outr` writes with `oa` 0..31. 16 output beats; `m_last` only on beat 15; `done` once.
- `s_valid` toggling 50% → `src_a` sequence still 0..31 with no gaps or duplicates. EXEC starts the cycle after the 32nd handshake.
- `m_ready` stalls of 5 cycles on beats 3 and 15 → `m_data` held during stalls. No extra `dst_v` while stalled.
- `NPASS`=2 → `exec` high for exactly 128 cycles, with `ia` wrapping 63→0 once.
- `GEMM_CTRL_ERR_EN` defined, 33rd `result_v` → no `outr`; `err`=1 until the next `start`. Macro undefined, same stimulus → `err` stays 0.

Source files
------------

// File: rtl/gemm_ctrl.sv
// gemm_ctrl: sequences one GEMM tile job (load src_buf, sweep core issue, drain dst_buf).
// Optional sticky protocol error flag is built when GEMM_CTRL_ERR_EN is defined.
module gemm_ctrl #(
  parameter int unsigned NPASS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic        src_v,
  output logic [4:0]  src_a,
  output logic [63:0] src_d,
  output logic        exec,
  output logic [5:0]  ia,
  input  logic        result_v,
  output logic        outr,
  output logic [4:0]  oa,
  output logic        dst_v,
  output logic [3:0]  dst_a,
  input  logic [63:0] dst_d,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        m_last,
  output logic        err,
  output logic [2:0]  dbg_state_o
);
  // Handshakes: a beat transfers in any cycle with valid & ready both high; the
  // sender holds valid and data unchanged until that cycle.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_EXEC, S_WAIT, S_DR_ISSUE, S_DR_CAPT, S_DR_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic [5:0]  ia_q, ia_d;
  logic [3:0]  pass_q, pass_d;
  logic [5:0]  rcnt_q, rcnt_d;
  logic [3:0]  k_q, k_d;
  logic        src_v_q, src_v_d;
  logic [4:0]  src_a_q, src_a_d;
  logic [63:0] src_d_q, src_d_d;
  logic        m_valid_q, m_valid_d;
  logic [63:0] m_data_q, m_data_d;
  logic        done_q, done_d;
  logic        start_acc, s_hs, m_hs, res_ok;

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    ia_d      = ia_q;
    pass_d    = pass_q;
    rcnt_d    = rcnt_q;
    k_d       = k_q;
    src_v_d   = 1'b0;
    src_a_d   = src_a_q;
    src_d_d   = src_d_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    done_d    = 1'b0;
    dst_v     = 1'b0;
    dst_a     = 4'd0;
    s_ready   = (state_q == S_LOAD);
    s_hs      = s_valid & s_ready;
    m_hs      = m_valid_q & m_ready;
    start_acc = start & (state_q == S_IDLE);
    res_ok    = ((state_q == S_EXEC) || (state_q == S_WAIT)) && (rcnt_q < 6'd32);
    outr      = result_v & res_ok;
    if (outr) rcnt_d = rcnt_q + 6'd1;

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = S_LOAD;
          bcnt_d  = 5'd0;
          ia_d    = 6'd0;
          pass_d  = 4'd0;
          rcnt_d  = 6'd0;
          k_d     = 4'd0;
        end
      end
      S_LOAD: begin
        if (s_hs) begin
          src_v_d = 1'b1;
          src_a_d = bcnt_q;
          src_d_d = s_data;
          bcnt_d  = bcnt_q + 5'd1;
          if (bcnt_q == 5'd31) state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ia_d = ia_q + 6'd1;
        if (ia_q == 6'd63) begin
          pass_d = pass_q + 4'd1;
          if (pass_q == 4'(NPASS - 1)) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rcnt_q == 6'd32) state_d = S_DR_ISSUE;
      end
      S_DR_ISSUE: begin
        dst_v   = 1'b1;
        dst_a   = k_q;
        state_d = S_DR_CAPT;
      end
      S_DR_CAPT: begin
        dst_a     = k_q;
        m_data_d  = dst_d;
        m_valid_d = 1'b1;
        state_d   = S_DR_OUT;
      end
      S_DR_OUT: begin
        dst_a = k_q;
        if (m_hs) begin
          m_valid_d = 1'b0;
          if (k_q == 4'd15) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Next read issues alongside this handshake to keep two cycles per beat.
            dst_v   = 1'b1;
            dst_a   = k_q + 4'd1;
            k_d     = k_q + 4'd1;
            state_d = S_DR_CAPT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bcnt_q    <= 5'd0;
      ia_q      <= 6'd0;
      pass_q    <= 4'd0;
      rcnt_q    <= 6'd0;
      k_q       <= 4'd0;
      src_v_q   <= 1'b0;
      src_a_q   <= 5'd0;
      src_d_q   <= 64'd0;
      m_valid_q <= 1'b0;
      m_data_q  <= 64'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      ia_q      <= ia_d;
      pass_q    <= pass_d;
      rcnt_q    <= rcnt_d;
      k_q       <= k_d;
      src_v_q   <= src_v_d;
      src_a_q   <= src_a_d;
      src_d_q   <= src_d_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      done_q    <= done_d;
    end
  end

`ifdef GEMM_CTRL_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (start_acc) err_d = 1'b0;
    if (result_v && !res_ok) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign src_v       = src_v_q;
  assign src_a       = src_a_q;
  assign src_d       = src_d_q;
  assign exec        = (state_q == S_EXEC);
  assign ia          = ia_q;
  assign oa          = rcnt_q[4:0];
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_last      = m_valid_q & (k_q == 4'd15);
  assign dbg_state_o = state_q;
endmodule
